// File: rtl/pooling_backward_opt.sv
// Max-pool gradient router: selected lane gets data*error (fp32, RNE, FTZ), other lanes zero.
// Latency 7 clk, one window per clk, no backpressure (inputs sampled every cycle).
module pooling_backward_opt #(
  parameter int k_w = 3,
  parameter int k_h = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  max_flt_idx,
  input  logic [31:0] data_vect_in [k_w*k_h-1:0],
  input  logic [31:0] error_term,
  output logic [31:0] data_vect_out [k_w*k_h-1:0]
);

  localparam int WIDTH = k_w * k_h;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sign;
  } flags_t;

  // stage 0: lane select ahead of the register so only one operand pair is stored
  logic [31:0] sel_lane;
  always_comb begin
    sel_lane = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (max_flt_idx == 8'(i)) sel_lane = data_vect_in[i];
    end
  end

  logic [31:0] s0_a, s0_b;
  logic [7:0]  s0_idx;

  // multiplier stage 1: unpack, classify, sign and exponent
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  flags_t      u_flags;
  logic signed [9:0] u_exp;
  always_comb begin
    a_zero = (s0_a[30:23] == 8'h00);
    b_zero = (s0_b[30:23] == 8'h00);
    a_inf  = (s0_a[30:23] == 8'hFF) && (s0_a[22:0] == '0);
    b_inf  = (s0_b[30:23] == 8'hFF) && (s0_b[22:0] == '0);
    a_nan  = (s0_a[30:23] == 8'hFF) && (s0_a[22:0] != '0);
    b_nan  = (s0_b[30:23] == 8'hFF) && (s0_b[22:0] != '0);
    u_flags.nan  = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    u_flags.inf  = a_inf | b_inf;
    u_flags.zero = a_zero | b_zero;
    u_flags.sign = s0_a[31] ^ s0_b[31];
    u_exp = $signed({2'b00, s0_a[30:23]}) + $signed({2'b00, s0_b[30:23]}) - 10'sd127;
  end

  flags_t            m1_flags, m2_flags, m3_flags, m4_flags;
  logic signed [9:0] m1_exp, m2_exp, m3_exp, m4_exp;
  logic [23:0]       m1_ma, m1_mb;
  logic [47:0]       m2_prod;
  logic [23:0]       m3_mant;
  logic              m3_g, m3_st;
  logic [22:0]       m4_frac;
  logic [31:0]       m5_res;
  logic [7:0]        idx_pipe [5];

  // stage 3: product is in [1,4), so at most a one-place right shift
  logic [23:0]       n_mant;
  logic              n_g, n_st;
  logic signed [9:0] n_exp;
  always_comb begin
    if (m2_prod[47]) begin
      n_mant = m2_prod[47:24];
      n_g    = m2_prod[23];
      n_st   = |m2_prod[22:0];
      n_exp  = m2_exp + 10'sd1;
    end else begin
      n_mant = m2_prod[46:23];
      n_g    = m2_prod[22];
      n_st   = |m2_prod[21:0];
      n_exp  = m2_exp;
    end
  end

  // stage 4: round to nearest even; a carry out renormalises to 1.0
  logic [24:0]       r_sum;
  logic [22:0]       r_frac;
  logic signed [9:0] r_exp;
  always_comb begin
    r_sum = {1'b0, m3_mant} + 25'(m3_g & (m3_st | m3_mant[0]));
    if (r_sum[24]) begin
      r_frac = r_sum[23:1];
      r_exp  = m3_exp + 10'sd1;
    end else begin
      r_frac = r_sum[22:0];
      r_exp  = m3_exp;
    end
  end

  // stage 5: specials take priority, then overflow/underflow of the rounded exponent
  logic [31:0] p_res;
  always_comb begin
    if (m4_flags.nan)
      p_res = 32'h7FC00000;
    else if (m4_flags.inf)
      p_res = {m4_flags.sign, 8'hFF, 23'h0};
    else if (m4_flags.zero)
      p_res = {m4_flags.sign, 31'h0};
    else if (m4_exp >= 10'sd255)
      p_res = {m4_flags.sign, 8'hFF, 23'h0};
    else if (m4_exp <= 10'sd0)
      p_res = {m4_flags.sign, 31'h0};
    else
      p_res = {m4_flags.sign, m4_exp[7:0], m4_frac};
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      s0_a     <= '0;
      s0_b     <= '0;
      s0_idx   <= '0;
      m1_flags <= '0;
      m1_exp   <= '0;
      m1_ma    <= '0;
      m1_mb    <= '0;
      m2_flags <= '0;
      m2_exp   <= '0;
      m2_prod  <= '0;
      m3_flags <= '0;
      m3_exp   <= '0;
      m3_mant  <= '0;
      m3_g     <= 1'b0;
      m3_st    <= 1'b0;
      m4_flags <= '0;
      m4_exp   <= '0;
      m4_frac  <= '0;
      m5_res   <= '0;
      for (int i = 0; i < 5; i++) idx_pipe[i] <= '0;
      for (int i = 0; i < WIDTH; i++) data_vect_out[i] <= '0;
    end else begin
      s0_a     <= sel_lane;
      s0_b     <= error_term;
      s0_idx   <= max_flt_idx;

      m1_flags <= u_flags;
      m1_exp   <= u_exp;
      m1_ma    <= {1'b1, s0_a[22:0]};
      m1_mb    <= {1'b1, s0_b[22:0]};

      m2_flags <= m1_flags;
      m2_exp   <= m1_exp;
      m2_prod  <= {24'h0, m1_ma} * {24'h0, m1_mb};

      m3_flags <= m2_flags;
      m3_exp   <= n_exp;
      m3_mant  <= n_mant;
      m3_g     <= n_g;
      m3_st    <= n_st;

      m4_flags <= m3_flags;
      m4_exp   <= r_exp;
      m4_frac  <= r_frac;

      m5_res   <= p_res;

      // index travels with its product so the scatter matches the right window
      idx_pipe[0] <= s0_idx;
      for (int i = 1; i < 5; i++) idx_pipe[i] <= idx_pipe[i-1];

      for (int i = 0; i < WIDTH; i++)
        data_vect_out[i] <= (idx_pipe[4] == 8'(i)) ? m5_res : 32'h0;
    end
  end

endmodule

// File: tb/tb_pooling_backward_opt.sv
// Bench for pooling_backward_opt: directed literal cases plus randomized windows checked against a real-arithmetic model.
module tb_pooling_backward_opt;

  localparam int WIDTH = 9;
  localparam int LAT   = 7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  max_flt_idx;
  logic [31:0] data_vect_in  [WIDTH-1:0];
  logic [31:0] error_term;
  logic [31:0] data_vect_out [WIDTH-1:0];

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        cur;
  logic [31:0] push_val;

  pooling_backward_opt #(.k_w(3), .k_h(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .max_flt_idx   (max_flt_idx),
    .data_vect_in  (data_vect_in),
    .error_term    (error_term),
    .data_vect_out (data_vect_out)
  );

  always #5 clk = ~clk;

  // fp32 product via exact double multiply, then RNE to 24 bits with flush-to-zero
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [63:0] db;
    logic [24:0] m;
    real         ra, rb;
    int          de;
    s = a[31] ^ b[31];
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
      return 32'h7FC00000;
    if ((a[30:23] == 8'hFF && b[30:23] == 8'h00) || (a[30:23] == 8'h00 && b[30:23] == 8'hFF))
      return 32'h7FC00000;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {s, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    ra = $bitstoreal({1'b0, 11'(int'(a[30:23]) + 896), a[22:0], 29'h0});
    rb = $bitstoreal({1'b0, 11'(int'(b[30:23]) + 896), b[22:0], 29'h0});
    db = $realtobits(ra * rb);
    de = int'(db[62:52]) - 896;
    m  = {2'b01, db[51:29]};
    if (db[28] && ((|db[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      de = de + 1;
      m  = m >> 1;
    end
    if (de >= 255) return {s, 8'hFF, 23'h0};
    if (de <= 0)   return {s, 31'h0};
    return {s, 8'(de), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom());
    case ($urandom_range(0, 15))
      0: begin e = 8'h00; f = '0; end
      1: e = 8'h00;
      2: begin e = 8'hFF; f = '0; end
      3: begin e = 8'hFF; f = f | 23'h1; end
      4: e = 8'($urandom_range(200, 254));
      5: e = 8'($urandom_range(1, 40));
      6: begin e = 8'($urandom_range(120, 135)); f = {f[22:11], 11'h0}; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  task automatic check_out(input string name, input logic [7:0] idx, input logic [31:0] expv);
    logic [31:0] e;
    logic        bad;
    bad = 1'b0;
    checks++;
    for (int i = 0; i < WIDTH; i++) begin
      e = (idx == 8'(i)) ? expv : 32'h0;
      if (!bad && data_vect_out[i] !== e) begin
        bad = 1'b1;
        errors++;
        $display("FAIL %s t=%0t lane %0d: got %h expected %h", name, $time, i, data_vect_out[i], e);
      end
    end
  endtask

  // expected result for each sampled window, queued in sampling order
  always @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      exp_q.delete();
    end else begin
      push_val = 32'h0;
      if (max_flt_idx < 8'(WIDTH)) push_val = ref_mul(data_vect_in[max_flt_idx], error_term);
      exp_q.push_back('{idx: max_flt_idx, val: push_val});
    end
  end

  // every cycle: either a window has completed its latency or the pipe still shows zeros
  always @(negedge clk) begin
    cur = '{idx: 8'hFF, val: 32'h0};
    if (!reset_n && exp_q.size() >= LAT) cur = exp_q.pop_front();
    check_out("model", cur.idx, cur.val);
  end

  task automatic directed(input string name, input logic [7:0] idx, input logic [31:0] dv,
                          input logic [31:0] err, input logic [31:0] expv);
    for (int i = 0; i < WIDTH; i++) data_vect_in[i] = 32'h41200000;
    if (idx < 8'(WIDTH)) data_vect_in[idx] = dv;
    max_flt_idx = idx;
    error_term  = err;
    @(negedge clk);
    max_flt_idx = 8'hFF;
    repeat (LAT - 1) @(negedge clk);
    #1 check_out(name, idx, expv);
  endtask

  initial begin
    max_flt_idx = 8'hFF;
    error_term  = 32'h0;
    for (int i = 0; i < WIDTH; i++) data_vect_in[i] = 32'h0;
    #1 reset_n = 1'b1;
    #1 check_out("reset_state", 8'hFF, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;

    directed("idx4_2x1p5",   8'd4,   32'h40000000, 32'h3FC00000, 32'h40400000);
    directed("idx0_neg",     8'd0,   32'hC0000000, 32'h3F000000, 32'hBF800000);
    directed("idx8_x100",    8'd8,   32'h3F800000, 32'h42C80000, 32'h42C80000);
    directed("zero_x_inf",   8'd2,   32'h00000000, 32'h7F800000, 32'h7FC00000);
    directed("overflow",     8'd2,   32'h7F000000, 32'h40000000, 32'h7F800000);
    directed("denormal",     8'd2,   32'h00400000, 32'h3F800000, 32'h00000000);
    directed("idx9_empty",   8'd9,   32'h40000000, 32'h3FC00000, 32'h00000000);
    directed("idx255_empty", 8'd255, 32'h40000000, 32'h3FC00000, 32'h00000000);

    // back-to-back windows on lanes 1,3,5 with error term 2.0
    @(negedge clk);
    for (int i = 0; i < WIDTH; i++) data_vect_in[i] = 32'h41200000;
    data_vect_in[1] = 32'h40400000;
    data_vect_in[3] = 32'h3F800000;
    data_vect_in[5] = 32'hC1000000;
    error_term  = 32'h40000000;
    max_flt_idx = 8'd1;
    @(negedge clk) max_flt_idx = 8'd3;
    @(negedge clk) max_flt_idx = 8'd5;
    @(negedge clk) max_flt_idx = 8'hFF;
    repeat (LAT - 3) @(negedge clk);
    #1 check_out("stream_1", 8'd1, 32'h40C00000);
    @(negedge clk);
    #1 check_out("stream_3", 8'd3, 32'h40000000);
    @(negedge clk);
    #1 check_out("stream_5", 8'd5, 32'hC1800000);

    for (int c = 0; c < 400; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 19);
      if (r <= 16)      max_flt_idx = 8'($urandom_range(0, WIDTH - 1));
      else if (r == 17) max_flt_idx = 8'd9;
      else if (r == 18) max_flt_idx = 8'($urandom_range(10, 254));
      else              max_flt_idx = 8'd255;
      for (int i = 0; i < WIDTH; i++) data_vect_in[i] = rand_fp();
      error_term = rand_fp();
    end

    // stream of nonzero results, then an asynchronous reset between edges
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < WIDTH; i++) data_vect_in[i] = 32'h3F800000 | (32'(i) << 16);
      error_term  = 32'h40000000;
      max_flt_idx = 8'(c % WIDTH);
    end
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1 check_out("async_reset", 8'hFF, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    directed("post_reset", 8'd4, 32'h40000000, 32'h3FC00000, 32'h40400000);

    repeat (3) @(negedge clk);
    #1 $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
